// File: rtl/dac_output_parallel.sv
// Parallel DAC output stage: buffers AXI-Stream samples in a small FIFO and
// presents them on a divided DAC latch clock, tracking I/Q order for dual DACs.
module dac_output_parallel #(
    parameter int    DW_DAC     = 10,
    parameter int    DW_BUS     = 16,
    parameter string FILL       = "MSB",
    parameter int    DAC_IQ     = 1,
    parameter int    CLK_DIV    = 4,
    parameter int    FIFO_DEPTH = 8
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              ce,
    input  logic [DW_BUS-1:0] tdata_s_in,
    input  logic              tid_s_in,
    input  logic              tvalid_s_in,
    output logic              tready_s_out,
    output logic              dac_clk,
    output logic              dac_channel_sel,
    output logic [DW_DAC-1:0] dac_data,
    output logic              underflow_out,
    output logic              sync_err_out
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OW = PW + 1;
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] PH_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] PH_HIGH  = CW'(CLK_DIV / 2);
    localparam logic [OW-1:0] OCC_FULL = OW'(FIFO_DEPTH);

    logic [CW-1:0]     phase_q, phase_d;
    logic              dac_clk_q, dac_clk_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]     count_q, count_d;
    logic [DW_DAC-1:0] data_q, data_d;
    logic              sel_q, sel_d;
    logic              exp_q, exp_d;
    logic              underflow_q, underflow_d;
    logic              sync_err_q, sync_err_d;
    logic [DW_DAC:0]   mem_q [FIFO_DEPTH];

    logic [DW_DAC-1:0] sample_in;
    logic [DW_DAC:0]   head_w;
    logic [DW_DAC-1:0] head_sample;
    logic              head_tid;
    logic              head_match;
    logic              wrap;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              unused_tdata;

    generate
        if (FILL == "LSB") begin : g_fill_lsb
            assign sample_in = tdata_s_in[DW_DAC-1:0];
        end else begin : g_fill_msb
            assign sample_in = tdata_s_in[DW_BUS-1 -: DW_DAC];
        end
    endgenerate

    assign unused_tdata = ^tdata_s_in;

    // Valid/ready: a beat moves on any rising aclk edge where tvalid_s_in and
    // tready_s_out are both high; ready depends only on ce and registered
    // occupancy, never on tvalid, and is held low while reset is asserted.
    assign tready_s_out = aresetn & ce & (count_q < OCC_FULL);
    assign push         = tvalid_s_in & tready_s_out;

    // The update edge is the counter wrap, which is also the dac_clk fall.
    assign wrap       = ce & (phase_q == PH_LAST);
    assign fifo_empty = (count_q == '0);
    assign pop        = wrap & ~fifo_empty;

    assign head_w      = mem_q[rd_ptr_q];
    assign head_sample = head_w[DW_DAC-1:0];
    assign head_tid    = head_w[DW_DAC];
    assign head_match  = (DAC_IQ == 0) || (head_tid == exp_q);

    always_comb begin
        phase_d     = '0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_d      = data_q;
        sel_d       = sel_q;
        exp_d       = exp_q;
        underflow_d = 1'b0;
        sync_err_d  = 1'b0;

        if (ce && !wrap) begin
            phase_d = phase_q + 1'b1;
        end
        dac_clk_d = (phase_d >= PH_HIGH);

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A mismatched head is still consumed so the stream can realign.
        if (wrap) begin
            if (fifo_empty) begin
                underflow_d = 1'b1;
            end else if (!head_match) begin
                sync_err_d = 1'b1;
            end else begin
                data_d = head_sample;
                sel_d  = head_tid;
                if (DAC_IQ != 0) begin
                    exp_d = ~exp_q;
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            phase_q     <= '0;
            dac_clk_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_q      <= '0;
            sel_q       <= 1'b0;
            exp_q       <= 1'b0;
            underflow_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            dac_clk_q   <= dac_clk_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_q      <= data_d;
            sel_q       <= sel_d;
            exp_q       <= exp_d;
            underflow_q <= underflow_d;
            sync_err_q  <= sync_err_d;
        end
    end

    // Storage needs no reset: the occupancy count alone defines valid entries.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {tid_s_in, sample_in};
        end
    end

    assign dac_clk         = dac_clk_q;
    assign dac_data        = data_q;
    assign dac_channel_sel = (DAC_IQ != 0) ? sel_q : aresetn;
    assign underflow_out   = underflow_q;
    assign sync_err_out    = sync_err_q;

endmodule

// File: tb/tb_dac_output_parallel.sv
// Directed bench for dac_output_parallel: an IQ/MSB instance driven from a
// vector table plus corner sequences, and an LSB single-channel instance.
module tb_dac_output_parallel;

    localparam int DW_DAC  = 10;
    localparam int DW_BUS  = 16;
    localparam int CLK_DIV = 4;
    localparam int NV      = 10;

    typedef struct {
        logic [15:0] tdata;
        logic        tid;
        logic [9:0]  exp_data;
        logic        exp_sel;
        logic        exp_sync;
    } vec_t;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic              ce, tid, tvalid;
    logic [DW_BUS-1:0] tdata;
    logic              tready, dac_clk, dac_channel_sel, underflow, sync_err;
    logic [DW_DAC-1:0] dac_data;

    logic              ce2, tid2, tvalid2;
    logic [DW_BUS-1:0] tdata2;
    logic              tready2, dclk2, sel2, uf2, se2;
    logic [DW_DAC-1:0] data2;

    int          n_checks = 0;
    int          n_fail   = 0;
    vec_t        vec [NV];
    logic [9:0]  exp_q [$];

    always #5 aclk = ~aclk;

    dac_output_parallel #(
        .DW_DAC(DW_DAC), .DW_BUS(DW_BUS), .FILL("MSB"), .DAC_IQ(1),
        .CLK_DIV(CLK_DIV), .FIFO_DEPTH(8)
    ) u_dut (
        .aclk(aclk), .aresetn(aresetn), .ce(ce), .tdata_s_in(tdata),
        .tid_s_in(tid), .tvalid_s_in(tvalid), .tready_s_out(tready),
        .dac_clk(dac_clk), .dac_channel_sel(dac_channel_sel), .dac_data(dac_data),
        .underflow_out(underflow), .sync_err_out(sync_err)
    );

    dac_output_parallel #(
        .DW_DAC(DW_DAC), .DW_BUS(DW_BUS), .FILL("LSB"), .DAC_IQ(0),
        .CLK_DIV(CLK_DIV), .FIFO_DEPTH(8)
    ) u_dut_lsb (
        .aclk(aclk), .aresetn(aresetn), .ce(ce2), .tdata_s_in(tdata2),
        .tid_s_in(tid2), .tvalid_s_in(tvalid2), .tready_s_out(tready2),
        .dac_clk(dclk2), .dac_channel_sel(sel2), .dac_data(data2),
        .underflow_out(uf2), .sync_err_out(se2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        ce      = 1'b0;
        tvalid  = 1'b0;
        ce2     = 1'b0;
        tvalid2 = 1'b0;
        repeat (3) step();
        aresetn = 1'b1;
    endtask

    task automatic push_beat(input logic [15:0] data, input logic id);
        int waited;
        tvalid = 1'b1;
        tdata  = data;
        tid    = id;
        waited = 0;
        #1;
        while (!tready && waited < 100) begin
            @(posedge aclk);
            #2;
            waited++;
        end
        n_checks++;
        if (!tready) begin
            n_fail++;
            $display("FAIL push_timeout: tready low for %0d cycles, expected high", waited);
        end
        @(posedge aclk);
        #1;
        tvalid = 1'b0;
    endtask

    // Steps until the selected DAC clock falls, i.e. one update edge has passed.
    task automatic wait_fall(input bit lsb, input string name, output int cyc);
        logic prev;
        bit   found;
        found = 1'b0;
        cyc   = 0;
        prev  = lsb ? dclk2 : dac_clk;
        while (!found && cyc < 4 * CLK_DIV) begin
            step();
            cyc++;
            if (prev && !(lsb ? dclk2 : dac_clk)) found = 1'b1;
            prev = lsb ? dclk2 : dac_clk;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s: dac_clk did not fall within %0d cycles, expected a falling edge", name, cyc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cyc;
        int         acc;
        logic       got;
        logic [9:0] exp_d;

        vec[0] = '{16'hFFC0, 1'b0, 10'h3FF, 1'b0, 1'b0};
        vec[1] = '{16'h0040, 1'b1, 10'h001, 1'b1, 1'b0};
        vec[2] = '{16'h8000, 1'b0, 10'h200, 1'b0, 1'b0};
        vec[3] = '{16'h0000, 1'b0, 10'h200, 1'b0, 1'b1};
        vec[4] = '{16'h7FC0, 1'b1, 10'h1FF, 1'b1, 1'b0};
        vec[5] = '{16'hABCD, 1'b0, 10'h2AF, 1'b0, 1'b0};
        vec[6] = '{16'h1234, 1'b1, 10'h048, 1'b1, 1'b0};
        vec[7] = '{16'h003F, 1'b1, 10'h048, 1'b1, 1'b1};
        vec[8] = '{16'h0FFF, 1'b0, 10'h03F, 1'b0, 1'b0};
        vec[9] = '{16'hFFFF, 1'b1, 10'h3FF, 1'b1, 1'b0};

        tdata = '0; tid = 1'b0; tvalid = 1'b0;
        tdata2 = '0; tid2 = 1'b0; tvalid2 = 1'b0; ce2 = 1'b0;

        // Reset state, with ce high to show ready stays low in reset
        aresetn = 1'b0;
        ce      = 1'b1;
        repeat (3) step();
        check("rst_tready", tready, 0);
        check("rst_dac_clk", dac_clk, 0);
        check("rst_dac_data", dac_data, 0);
        check("rst_sel", dac_channel_sel, 0);
        check("rst_underflow", underflow, 0);
        check("rst_sync_err", sync_err, 0);
        check("rst_lsb_sel", sel2, 0);
        ce      = 1'b0;
        aresetn = 1'b1;
        step();

        // LSB fill, single channel: tid ignored, select stuck at 1
        check("lsb_sel_const", sel2, 1);
        ce2 = 1'b1; tvalid2 = 1'b1; tdata2 = 16'h0155; tid2 = 1'b0;
        step();
        tdata2 = 16'hFEAA;
        step();
        tvalid2 = 1'b0;
        wait_fall(1'b1, "lsb_update0", cyc);
        check("lsb_data0", data2, 10'h155);
        check("lsb_sel0", sel2, 1);
        wait_fall(1'b1, "lsb_update1", cyc);
        check("lsb_data1", data2, 10'h2AA);
        check("lsb_sel1", sel2, 1);
        check("lsb_no_sync_err", se2, 0);
        ce2 = 1'b0;

        // Table-driven IQ/MSB stream, including drops and FIFO wrap
        do_reset();
        for (int i = 0; i < NV; i++) exp_q.push_back(vec[i].exp_data);
        ce = 1'b1;
        fork
            begin
                for (int i = 0; i < NV; i++) push_beat(vec[i].tdata, vec[i].tid);
            end
        join_none
        for (int i = 0; i < NV; i++) begin
            wait_fall(1'b0, $sformatf("vec%0d_update", i), cyc);
            exp_d = exp_q.pop_front();
            check($sformatf("vec%0d_data", i), dac_data, exp_d);
            check($sformatf("vec%0d_sel", i), dac_channel_sel, vec[i].exp_sel);
            check($sformatf("vec%0d_sync_err", i), sync_err, vec[i].exp_sync);
            check($sformatf("vec%0d_underflow", i), underflow, 0);
            cyc = 0;
            while (!dac_clk && cyc < 2 * CLK_DIV) begin
                step();
                cyc++;
            end
            check($sformatf("vec%0d_setup_cycles", i), cyc, 2);
            check($sformatf("vec%0d_data_at_rise", i), dac_data, exp_d);
        end

        // Starvation: underflow holds outputs, then the next I sample resumes
        wait_fall(1'b0, "underflow_update", cyc);
        check("uf_pulse", underflow, 1);
        check("uf_data_hold", dac_data, 10'h3FF);
        check("uf_sel_hold", dac_channel_sel, 1);
        check("uf_no_sync_err", sync_err, 0);
        step();
        check("uf_one_cycle", underflow, 0);
        push_beat(16'h4000, 1'b0);
        wait_fall(1'b0, "resume_update", cyc);
        check("resume_data", dac_data, 10'h100);
        check("resume_sel", dac_channel_sel, 0);
        check("resume_underflow", underflow, 0);

        // Fill to full with ce dropped before each wrap so nothing is popped
        do_reset();
        acc    = 0;
        tvalid = 1'b1;
        tdata  = 16'(1 << 6);
        tid    = 1'b0;
        for (int c = 0; c < 12; c++) begin
            ce = (c % 4 != 3);
            #1;
            if (c == 10) check("full_tready_low", tready, 0);
            got = tvalid & tready;
            @(posedge aclk);
            #1;
            if (got) begin
                acc++;
                tdata = 16'((acc + 1) << 6);
                tid   = acc[0];
            end
        end
        check("full_accepted", acc, 8);
        check("full_no_update", dac_data, 0);
        ce = 1'b1;
        for (int c = 0; c < CLK_DIV; c++) begin
            #1;
            check($sformatf("stall%0d_tready_low", c), tready, 0);
            @(posedge aclk);
            #1;
        end
        check("pop_dac_clk_fell", dac_clk, 0);
        check("pop_data", dac_data, 1);
        check("pop_sel", dac_channel_sel, 0);
        check("tready_reraised", tready, 1);
        step();
        check("refill_tready_low", tready, 0);
        tvalid = 1'b0;

        // Drain to half full, then reset mid-operation
        for (int k = 2; k <= 5; k++) begin
            wait_fall(1'b0, $sformatf("drain%0d_update", k), cyc);
            check($sformatf("drain%0d_data", k), dac_data, k);
            check($sformatf("drain%0d_sel", k), dac_channel_sel, (k - 1) % 2);
        end
        #2;
        aresetn = 1'b0;
        #1;
        check("mid_rst_data", dac_data, 0);
        check("mid_rst_sel", dac_channel_sel, 0);
        check("mid_rst_dac_clk", dac_clk, 0);
        check("mid_rst_tready", tready, 0);
        check("mid_rst_underflow", underflow, 0);
        check("mid_rst_sync_err", sync_err, 0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        wait_fall(1'b0, "post_rst_update", cyc);
        check("post_rst_latency", cyc, CLK_DIV);
        check("post_rst_underflow", underflow, 1);
        check("post_rst_data", dac_data, 0);
        check("post_rst_sel", dac_channel_sel, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
